// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: op encodings, FSM states and the
// byte-lane helpers used by the alignment logic.
package mem_pkg;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        logic r;
        r = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: r = lo[0];
            OP_LW, OP_SW:         r = |lo;
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

    // Little-endian lane enables; loads use the same lanes as the matching store size.
    function automatic logic [3:0] calc_be(input logic [3:0] op, input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b0000;
        case (op)
            OP_LB, OP_LBU, OP_SB: be = 4'b0001 << lo;
            OP_LH, OP_LHU, OP_SH: be = lo[1] ? 4'b1100 : 4'b0011;
            OP_LW, OP_SW:         be = 4'b1111;
            default:              be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate narrow store data across all lanes so the be mask picks the right one.
    function automatic logic [31:0] store_wdata(input logic [3:0] op, input logic [31:0] d);
        logic [31:0] w;
        case (op)
            OP_SB:   w = {4{d[7:0]}};
            OP_SH:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Pick the addressed lane out of the read word and sign/zero extend it.
    function automatic logic [31:0] extract_load(input logic [3:0] op, input logic [1:0] lo,
                                                 input logic [31:0] rdata);
        logic [31:0] sh;
        logic [15:0] half;
        logic [31:0] v;
        sh   = rdata >> {lo, 3'b000};
        half = lo[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   v = {{24{sh[7]}}, sh[7:0]};
            OP_LBU:  v = {24'd0, sh[7:0]};
            OP_LH:   v = {{16{half[15]}}, half};
            OP_LHU:  v = {16'd0, half};
            OP_LW:   v = rdata;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational byte-lane logic: enables, store replication, load extraction
// and misalignment detection for one memory op.
module mem_align
    import mem_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misalign,
    output logic        o_is_load,
    output logic        o_is_store
);

    // Pure lane decode; all heavy lifting lives in the package helpers.
    always_comb begin
        o_be        = calc_be(i_op, i_addr_lo);
        o_wdata     = store_wdata(i_op, i_store_data);
        o_load_data = extract_load(i_op, i_addr_lo, i_rdata);
        o_misalign  = is_misaligned(i_op, i_addr_lo);
        o_is_load   = is_load(i_op);
        o_is_store  = is_store(i_op);
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: ALU pass-through plus a req/ack data-memory FSM that
// stalls upstream while an access is outstanding.
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write_reg_en_i,
    input  logic [4:0]  mem_write_reg_addr_i,
    input  logic [31:0] mem_write_reg_data_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_store_data_i,
    output logic        wb_write_reg_en_o,
    output logic [4:0]  wb_write_reg_addr_o,
    output logic [31:0] wb_write_reg_data_o,
    output logic        stall_req_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_load;
    logic        r_err;
    logic        r_bus_err;

    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load;
    logic        w_misalign;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_issue;

    mem_align u_align (
        .i_op         (mem_op_i),
        .i_addr_lo    (mem_addr_i[1:0]),
        .i_store_data (mem_store_data_i),
        .i_rdata      (dmem_rdata_i),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load),
        .o_misalign   (w_misalign),
        .o_is_load    (w_is_load),
        .o_is_store   (w_is_store)
    );

    assign w_issue = (w_is_load | w_is_store) & ~w_misalign;

    // Access FSM; bus fields are registered on issue and cleared when the access ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 8'd0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_be      <= 4'd0;
            r_wdata   <= 32'd0;
            r_load    <= 32'd0;
            r_err     <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_we    <= w_is_store;
                        r_addr  <= {mem_addr_i[31:2], 2'b00};
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_cnt   <= 8'd0;
                        r_err   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    r_cnt <= r_cnt + 8'd1;
                    // Ack has priority over a timeout landing in the same cycle.
                    if (dmem_ack_i) begin
                        r_load  <= w_load;
                        r_state <= ST_DONE;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_addr  <= 32'd0;
                        r_be    <= 4'd0;
                        r_wdata <= 32'd0;
                    end else if (r_cnt == TO_LAST) begin
                        r_bus_err <= 1'b1;
                        r_err     <= 1'b1;
                        r_state   <= ST_DONE;
                        r_req     <= 1'b0;
                        r_we      <= 1'b0;
                        r_addr    <= 32'd0;
                        r_be      <= 4'd0;
                        r_wdata   <= 32'd0;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Writeback/stall steering per state; everything is forced low while in reset.
    always_comb begin
        stall_req_o         = 1'b0;
        misalign_o          = 1'b0;
        wb_write_reg_en_o   = mem_write_reg_en_i;
        wb_write_reg_addr_o = mem_write_reg_addr_i;
        wb_write_reg_data_o = mem_write_reg_data_i;
        dmem_req_o          = r_req;
        dmem_we_o           = r_we;
        dmem_addr_o         = r_addr;
        dmem_be_o           = r_be;
        dmem_wdata_o        = r_wdata;
        bus_err_o           = r_bus_err;
        case (r_state)
            ST_REQ: begin
                stall_req_o       = 1'b1;
                wb_write_reg_en_o = 1'b0;
            end
            ST_DONE: begin
                if (w_is_load) begin
                    wb_write_reg_en_o   = mem_write_reg_en_i & ~r_err;
                    wb_write_reg_data_o = r_load;
                end else begin
                    wb_write_reg_en_o   = 1'b0;
                end
            end
            default: begin
                if (w_is_load | w_is_store) begin
                    wb_write_reg_en_o = 1'b0;
                    misalign_o        = w_misalign;
                    stall_req_o       = ~w_misalign;
                end
            end
        endcase
        if (rst) begin
            stall_req_o         = 1'b0;
            misalign_o          = 1'b0;
            wb_write_reg_en_o   = 1'b0;
            wb_write_reg_addr_o = 5'd0;
            wb_write_reg_data_o = 32'd0;
            dmem_req_o          = 1'b0;
            dmem_we_o           = 1'b0;
            dmem_addr_o         = 32'd0;
            dmem_be_o           = 4'd0;
            dmem_wdata_o        = 32'd0;
            bus_err_o           = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage (TIMEOUT=4).
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_i;
    logic [4:0]  rd_i;
    logic [31:0] alu_i;
    logic [3:0]  op_i;
    logic [31:0] addr_i;
    logic [31:0] sdata_i;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        req;
    logic        we;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        mis;
    logic        berr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .mem_write_reg_en_i   (en_i),
        .mem_write_reg_addr_i (rd_i),
        .mem_write_reg_data_i (alu_i),
        .mem_op_i             (op_i),
        .mem_addr_i           (addr_i),
        .mem_store_data_i     (sdata_i),
        .wb_write_reg_en_o    (wb_en),
        .wb_write_reg_addr_o  (wb_addr),
        .wb_write_reg_data_o  (wb_data),
        .stall_req_o          (stall),
        .dmem_req_o           (req),
        .dmem_we_o            (we),
        .dmem_addr_o          (baddr),
        .dmem_be_o            (be),
        .dmem_wdata_o         (wdata),
        .dmem_rdata_i         (rdata),
        .dmem_ack_i           (ack),
        .misalign_o           (mis),
        .bus_err_o            (berr)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic        en;
        logic [4:0]  rd;
        logic [31:0] alu;
        int          waits;   // wait states before ack; 255 = never ack
        logic [31:0] rdata;
        logic        x_mis;
        logic [3:0]  x_be;
        logic        x_we;
        logic [31:0] x_baddr;
        logic [31:0] x_wdata;
        int          x_stall;
        int          x_reqs;
        int          x_errs;
        logic        x_wb_en;
        logic        chk_data;
        logic [31:0] x_wb_data;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " stall"}, 32'(stall), 32'd0);
        chk({tag, " req"}, 32'(req), 32'd0);
        chk({tag, " we"}, 32'(we), 32'd0);
        chk({tag, " baddr"}, baddr, 32'd0);
        chk({tag, " be"}, 32'(be), 32'd0);
        chk({tag, " wdata"}, wdata, 32'd0);
        chk({tag, " wb_en"}, 32'(wb_en), 32'd0);
        chk({tag, " wb_addr"}, 32'(wb_addr), 32'd0);
        chk({tag, " wb_data"}, wb_data, 32'd0);
        chk({tag, " misalign"}, 32'(mis), 32'd0);
        chk({tag, " bus_err"}, 32'(berr), 32'd0);
    endtask

    // Runs one instruction from its IDLE cycle through its completion cycle,
    // then a NONE op (with a stray ack) that must pass straight through.
    task automatic run_vec(input int idx, input vec_t v);
        int stall_n, req_n, err_n;
        logic done;
        logic [3:0]  c_be;
        logic        c_we;
        logic [31:0] c_addr, c_wdata;
        string t;
        t = $sformatf("v%0d", idx);
        stall_n = 0; req_n = 0; err_n = 0; done = 1'b0;
        c_be = '0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        @(posedge clk); #1;
        op_i = v.op; addr_i = v.addr; sdata_i = v.sdata;
        en_i = v.en; rd_i = v.rd; alu_i = v.alu; ack = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                ack = 1'b0;
            end
            #1;
            if (c == 0) chk({t, " misalign"}, 32'(mis), 32'(v.x_mis));
            if (req) begin
                req_n++;
                if (req_n == 1) begin
                    c_be = be; c_we = we; c_addr = baddr; c_wdata = wdata;
                end
            end
            if (stall) stall_n++;
            if (berr) err_n++;
            if (!stall) begin
                done = 1'b1;
                chk({t, " wb_en"}, 32'(wb_en), 32'(v.x_wb_en));
                chk({t, " wb_addr"}, 32'(wb_addr), 32'(v.rd));
                if (v.chk_data) chk({t, " wb_data"}, wb_data, v.x_wb_data);
                break;
            end
            if (req && v.waits != 255 && req_n == v.waits + 1) begin
                ack = 1'b1;
                rdata = v.rdata;
            end
        end
        if (!done) chk({t, " completion within budget"}, 32'd0, 32'd1);
        chk({t, " stall cycles"}, 32'(stall_n), 32'(v.x_stall));
        chk({t, " req cycles"}, 32'(req_n), 32'(v.x_reqs));
        chk({t, " bus_err pulses"}, 32'(err_n), 32'(v.x_errs));
        if (v.x_reqs > 0) begin
            chk({t, " be"}, 32'(c_be), 32'(v.x_be));
            chk({t, " we"}, 32'(c_we), 32'(v.x_we));
            chk({t, " baddr"}, c_addr, v.x_baddr);
            chk({t, " wdata"}, c_wdata, v.x_wdata);
        end
        @(posedge clk); #1;
        op_i = 4'd0; en_i = 1'b1; rd_i = 5'd9; alu_i = 32'h0BADF00D; ack = 1'b1;
        #1;
        chk({t, " next stall"}, 32'(stall), 32'd0);
        chk({t, " next req"}, 32'(req), 32'd0);
        chk({t, " next wb_en"}, 32'(wb_en), 32'd1);
        chk({t, " next wb_data"}, wb_data, 32'h0BADF00D);
    endtask

    initial begin
        //           op    addr          sdata         en rd  alu           wt   rdata         mis be       we baddr         wdata         st rq er wben cd wb_data
        vecs[0]  = '{4'd5, 32'h00001000, 32'h0,        1, 5,  32'h11111111, 0,   32'hDEADBEEF, 0, 4'b1111, 0, 32'h00001000, 32'h0,        2, 1, 0, 1, 1, 32'hDEADBEEF};
        vecs[1]  = '{4'd1, 32'h00001003, 32'h0,        1, 7,  32'h22222222, 3,   32'h80AA5511, 0, 4'b1000, 0, 32'h00001000, 32'h0,        5, 4, 0, 1, 1, 32'hFFFFFF80};
        vecs[2]  = '{4'd2, 32'h00001003, 32'h0,        1, 8,  32'h22222222, 3,   32'h80AA5511, 0, 4'b1000, 0, 32'h00001000, 32'h0,        5, 4, 0, 1, 1, 32'h00000080};
        vecs[3]  = '{4'd7, 32'h00002002, 32'h1234ABCD, 1, 3,  32'h33333333, 0,   32'h0,        0, 4'b1100, 1, 32'h00002000, 32'hABCDABCD, 2, 1, 0, 0, 0, 32'h0};
        vecs[4]  = '{4'd5, 32'h00001002, 32'h0,        1, 4,  32'h44444444, 0,   32'h0,        1, 4'b0000, 0, 32'h0,        32'h0,        0, 0, 0, 0, 1, 32'h44444444};
        vecs[5]  = '{4'd5, 32'h00001004, 32'h0,        1, 6,  32'h55555555, 255, 32'h0,        0, 4'b1111, 0, 32'h00001004, 32'h0,        5, 4, 1, 0, 0, 32'h0};
        vecs[6]  = '{4'd3, 32'h00001002, 32'h0,        1, 10, 32'h66666666, 1,   32'h80017FFF, 0, 4'b1100, 0, 32'h00001000, 32'h0,        3, 2, 0, 1, 1, 32'hFFFF8001};
        vecs[7]  = '{4'd4, 32'h00001000, 32'h0,        1, 11, 32'h77777777, 2,   32'h8001F00D, 0, 4'b0011, 0, 32'h00001000, 32'h0,        4, 3, 0, 1, 1, 32'h0000F00D};
        vecs[8]  = '{4'd6, 32'h00003001, 32'h000000A5, 1, 12, 32'h88888888, 0,   32'h0,        0, 4'b0010, 1, 32'h00003000, 32'hA5A5A5A5, 2, 1, 0, 0, 0, 32'h0};
        vecs[9]  = '{4'd8, 32'h00003004, 32'hCAFEF00D, 1, 13, 32'h99999999, 1,   32'h0,        0, 4'b1111, 1, 32'h00003004, 32'hCAFEF00D, 3, 2, 0, 0, 0, 32'h0};
        vecs[10] = '{4'd7, 32'h00002001, 32'h1234ABCD, 1, 14, 32'hAAAA0000, 0,   32'h0,        1, 4'b0000, 0, 32'h0,        32'h0,        0, 0, 0, 0, 1, 32'hAAAA0000};
        vecs[11] = '{4'd1, 32'h00001001, 32'h0,        1, 15, 32'hBBBBBBBB, 0,   32'h00007F00, 0, 4'b0010, 0, 32'h00001000, 32'h0,        2, 1, 0, 1, 1, 32'h0000007F};
        vecs[12] = '{4'd9, 32'h00001003, 32'h0,        1, 16, 32'hA5A5A5A5, 0,   32'h0,        0, 4'b0000, 0, 32'h0,        32'h0,        0, 0, 0, 1, 1, 32'hA5A5A5A5};
        vecs[13] = '{4'd2, 32'h00001002, 32'h0,        1, 17, 32'hCCCCCCCC, 0,   32'h00FF0000, 0, 4'b0100, 0, 32'h00001000, 32'h0,        2, 1, 0, 1, 1, 32'h000000FF};
        vecs[14] = '{4'd8, 32'h00003001, 32'h12345678, 1, 18, 32'hDDDDDDDD, 0,   32'h0,        1, 4'b0000, 0, 32'h0,        32'h0,        0, 0, 0, 0, 1, 32'hDDDDDDDD};

        // Reset with live inputs: every output must read 0.
        rst = 1'b1; ack = 1'b0; rdata = 32'h0;
        op_i = 4'd5; addr_i = 32'h00001000; sdata_i = 32'hFFFFFFFF;
        en_i = 1'b1; rd_i = 5'd31; alu_i = 32'hFFFFFFFF;
        repeat (2) @(posedge clk);
        #2;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0; op_i = 4'd0;

        for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

        // Reset while a load sits in REQ and the ack lands in the same cycle.
        @(posedge clk); #1;
        op_i = 4'd5; addr_i = 32'h00001000; en_i = 1'b1; rd_i = 5'd5;
        alu_i = 32'h12345678; ack = 1'b0;
        @(posedge clk); #2;
        chk("rst-in-REQ req before reset", 32'(req), 32'd1);
        rst = 1'b1; ack = 1'b1; rdata = 32'hDEADBEEF;
        #1;
        chk_all_zero("rst-in-REQ during");
        @(posedge clk); #1;
        rst = 1'b0; ack = 1'b0;
        op_i = 4'd0; addr_i = 32'h0; sdata_i = 32'h0; en_i = 1'b0; rd_i = 5'd0; alu_i = 32'h0;
        #1;
        chk_all_zero("rst-in-REQ after");
        @(posedge clk); #1;
        op_i = 4'd5; addr_i = 32'h00001000; en_i = 1'b1; rd_i = 5'd5;
        #1;
        chk("rst-in-REQ back in IDLE stall", 32'(stall), 32'd1);
        chk("rst-in-REQ back in IDLE wb_en", 32'(wb_en), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; op_i = 4'd0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage pipeline. Sits between the EX/MEM pipeline register (upstream) and the MEM/WB register (downstream).
- Passes ALU results straight through. Runs loads/stores over a req/ack data-memory bus using a small FSM.
- Raises a pipeline stall while an access is outstanding; flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 255, max cycles in REQ waiting for dmem_ack_i before abort (1..255, 8-bit counter).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- mem_write_reg_en_i  in  1  reg write enable from EX/MEM
- mem_write_reg_addr_i  in  5  destination register from EX/MEM
- mem_write_reg_data_i  in  32  ALU result from EX/MEM
- mem_op_i  in  4  NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8; other values treated as NONE
- mem_addr_i  in  32  effective byte address
- mem_store_data_i  in  32  store data (rt)
- wb_write_reg_en_o  out  1  to MEM/WB
- wb_write_reg_addr_o  out  5  to MEM/WB
- wb_write_reg_data_o  out  32  to MEM/WB
- stall_req_o  out  1  hold PC, IF/ID, ID/EX, EX/MEM this cycle
- dmem_req_o  out  1  bus request, registered
- dmem_we_o  out  1  1=store
- dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be_o  out  4  byte enables, little-endian lanes
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_rdata_i  in  32  read data, valid with ack
- dmem_ack_i  in  1  one-cycle completion
- misalign_o  out  1  misaligned access (combinational)
- bus_err_o  out  1  one-cycle pulse on timeout

Behaviour:
- FSM states: IDLE, REQ, DONE. All state, counter, and registered bus outputs are cleared by rst.
- Reset:
  - While rst=1, every output is 0.
  - On rst, the state goes to IDLE; an outstanding req is dropped without waiting for ack.
- Misalignment:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, is misaligned.
  - misalign_o=1 in IDLE. No request is issued, no stall is raised, and wb_write_reg_en_o=0.
- IDLE:
  - NONE op: outputs = inputs pass-through, stall_req_o=0.
  - Aligned memory op:
    - Register the bus fields: dmem_req_o=1 and dmem_we_o/addr/be/wdata from next cycle; counter=0.
    - Go to REQ. stall_req_o=1 and wb_write_reg_en_o=0 this cycle.
- REQ:
  - stall_req_o=1, wb_write_reg_en_o=0, counter increments each cycle.
  - On dmem_ack_i:
    - Latch the extracted load data into load_q.
    - Drop dmem_req_o (registered, so it goes low next cycle).
    - Go to DONE.
  - On counter==TIMEOUT-1 with no ack:
    - Drop the req, pulse bus_err_o, set err_q, go to DONE.
  - Ack and timeout in the same cycle: ack wins.
- DONE:
  - stall_req_o=0. Addr = mem_write_reg_addr_i.
  - Load: en=mem_write_reg_en_i&~err_q, data=load_q.
  - Store: en=0.
  - Always return to IDLE next cycle. EX/MEM advances at the end of DONE, so IDLE sees the next instruction.
- dmem_ack_i outside REQ: ignored.
- Minimum load/store occupancy is 3 cycles (IDLE, REQ with immediate ack, DONE). Each wait state adds 1.
- Byte lanes (little-endian), lane = addr[1:0]:
  - SB: be=1<<lane, wdata={4{d[7:0]}}.
  - SH: be=addr[1]?1100:0011, wdata={2{d[15:0]}}.
  - SW: be=1111, wdata=d.
  - Loads: be per size as for stores.
- Load extraction: LB/LH sign-extend, LBU/LHU zero-extend the selected lane; LW takes the full word.

Decomposition:
- Shared package mem_pkg:
  - mem_op encoding constants (NONE..SW).
  - FSM state encodings.
  - Function to compute byte enables.
  - Function to extract/extend load data.
- One natural sub-module: mem_align. It is combinational: op + addr[1:0] + store data/rdata produces be, wdata, load value, and misalign. Reused by the bench's reference model.

Test Plan:
- LW addr 0x00001000, ack in first REQ cycle, rdata 0xDEADBEEF, en=1, rd=5 -> stall high 2 cycles; DONE cycle wb_en=1, rd=5, data=0xDEADBEEF.
- LB addr 0x00001003, 3 wait states, rdata 0x80AA5511 -> dmem_be=1000, stall 5 cycles, wb_data=0xFFFFFF80; repeat as LBU -> 0x00000080.
- SH addr 0x00002002, data 0x1234ABCD -> dmem_we=1, dmem_addr=0x00002000, be=1100, wdata=0xABCDABCD; DONE wb_en=0.
- LW addr 0x00001002 -> misalign_o=1, no dmem_req, no stall, wb_en=0; next NONE op passes data through unchanged.
- LW with no ack, TIMEOUT=4 -> req high 4 cycles, bus_err_o pulses once, DONE wb_en=0, FSM back to IDLE.
- rst asserted during REQ, with ack arriving same cycle -> next cycle all outputs 0, state IDLE, ack ignored, no writeback.
